// File: rtl/dag_addr_sched.sv
// -----------------------------------------------------------------------------
// dag_addr_sched
//   Address scheduler in front of the DAG modulo datapath. Holds the I/M/L
//   register files and round-robin arbitrates two requesters (A = data-memory
//   port, B = program-memory port) onto one shared, external, combinational
//   modulo unit. Two-stage flow:
//     ARB   : pick a winner, latch its select lines and I/M/L operands.
//     ISSUE : pulse the winner's grant, present the pre-update address and the
//             modulo operands, then write mod_newi back into I[isel].
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_isel/a_msel/a_gnt  requester A (data memory)
//   b_req/b_isel/b_msel/b_gnt  requester B (program memory)
//   addr, addr_vld, addr_src   issued address, valid strobe, source (0=A,1=B)
//   wrap_o                     modulo wrap flag qualified by addr_vld
//   mod_i/mod_m/mod_l          operands to the external modulo unit
//   mod_newi, mod_wrap         result and wrap flag from the modulo unit
//   wr_en/wr_kind/wr_sel/wr_data  host register write (kind 0=I,1=M,2=L,3=none)
// -----------------------------------------------------------------------------
module dag_addr_sched #(
  parameter int AW   = 14,
  parameter int NREG = 4,
  localparam int SW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic [SW-1:0] a_isel,
  input  logic [SW-1:0] a_msel,
  output logic          a_gnt,
  input  logic          b_req,
  input  logic [SW-1:0] b_isel,
  input  logic [SW-1:0] b_msel,
  output logic          b_gnt,
  output logic [AW-1:0] addr,
  output logic          addr_vld,
  output logic          addr_src,
  output logic          wrap_o,
  output logic [AW-1:0] mod_i,
  output logic [AW-1:0] mod_m,
  output logic [AW-1:0] mod_l,
  input  logic [AW-1:0] mod_newi,
  input  logic          mod_wrap,
  input  logic          wr_en,
  input  logic [1:0]    wr_kind,
  input  logic [SW-1:0] wr_sel,
  input  logic [AW-1:0] wr_data
);

  localparam logic [1:0] KIND_I = 2'd0;
  localparam logic [1:0] KIND_M = 2'd1;
  localparam logic [1:0] KIND_L = 2'd2;

  // True when the host write in this cycle targets register file `kind` at `sel`.
  function automatic logic host_hit(input logic          en,
                                    input logic [1:0]    kind,
                                    input logic [SW-1:0] sel,
                                    input logic [1:0]    want_kind,
                                    input logic [SW-1:0] want_sel);
    return en && (kind == want_kind) && (sel == want_sel);
  endfunction

  // Register files
  logic [AW-1:0] i_q [NREG];
  logic [AW-1:0] m_q [NREG];
  logic [AW-1:0] l_q [NREG];

  // ISSUE stage registers
  logic          iss_vld_q, iss_vld_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          iss_src_q, iss_src_d;
  logic [SW-1:0] iss_isel_q, iss_isel_d;
  logic [AW-1:0] iss_i_q, iss_i_d;
  logic [AW-1:0] iss_m_q, iss_m_d;
  logic [AW-1:0] iss_l_q, iss_l_d;

  // Round-robin pointer: 0 = A won last tie, 1 = B won last tie
  logic          last_q, last_d;

  logic          host_wr_s;
  logic          arb_go_s;
  logic          arb_src_s;
  logic [SW-1:0] sel_isel_s;
  logic [SW-1:0] sel_msel_s;
  logic          wb_en_s;

  // A host write to any file stalls arbitration for the cycle.
  assign host_wr_s = wr_en && (wr_kind != 2'd3);

  // Writeback is dropped when the host writes the same I register this cycle.
  assign wb_en_s = iss_vld_q && !host_hit(wr_en, wr_kind, wr_sel, KIND_I, iss_isel_q);

  // Arbitration: single requester wins outright; on a tie the requester
  // other than the last tie winner takes it and the pointer moves.
  always_comb begin
    arb_go_s  = 1'b0;
    arb_src_s = 1'b0;
    last_d    = last_q;
    if (host_wr_s) begin
      arb_go_s = 1'b0;
    end else if (a_req && b_req) begin
      arb_go_s  = 1'b1;
      arb_src_s = ~last_q;
      last_d    = ~last_q;
    end else if (a_req) begin
      arb_go_s  = 1'b1;
      arb_src_s = 1'b0;
    end else if (b_req) begin
      arb_go_s  = 1'b1;
      arb_src_s = 1'b1;
    end else begin
      arb_go_s  = 1'b0;
    end
  end

  // Operand fetch with forwarding: host write data first, then the in-flight
  // modulo result for the same I register, else the register file.
  always_comb begin
    sel_isel_s = arb_src_s ? b_isel : a_isel;
    sel_msel_s = arb_src_s ? b_msel : a_msel;

    iss_i_d = i_q[sel_isel_s];
    if (host_hit(wr_en, wr_kind, wr_sel, KIND_I, sel_isel_s)) begin
      iss_i_d = wr_data;
    end else if (iss_vld_q && (iss_isel_q == sel_isel_s)) begin
      iss_i_d = mod_newi;
    end else begin
      iss_i_d = i_q[sel_isel_s];
    end

    iss_m_d = m_q[sel_msel_s];
    if (host_hit(wr_en, wr_kind, wr_sel, KIND_M, sel_msel_s)) begin
      iss_m_d = wr_data;
    end else begin
      iss_m_d = m_q[sel_msel_s];
    end

    // L register follows the index select
    iss_l_d = l_q[sel_isel_s];
    if (host_hit(wr_en, wr_kind, wr_sel, KIND_L, sel_isel_s)) begin
      iss_l_d = wr_data;
    end else begin
      iss_l_d = l_q[sel_isel_s];
    end
  end

  // Next state of the ISSUE stage; payload holds when nothing is granted.
  always_comb begin
    iss_vld_d  = arb_go_s;
    a_gnt_d    = arb_go_s && !arb_src_s;
    b_gnt_d    = arb_go_s && arb_src_s;
    iss_src_d  = iss_src_q;
    iss_isel_d = iss_isel_q;
    if (arb_go_s) begin
      iss_src_d  = arb_src_s;
      iss_isel_d = sel_isel_s;
    end else begin
      iss_src_d  = iss_src_q;
      iss_isel_d = iss_isel_q;
    end
  end

  // ISSUE stage and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q  <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      iss_src_q  <= 1'b0;
      iss_isel_q <= '0;
      iss_i_q    <= '0;
      iss_m_q    <= '0;
      iss_l_q    <= '0;
      last_q     <= 1'b1;
    end else begin
      iss_vld_q  <= iss_vld_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      iss_src_q  <= iss_src_d;
      iss_isel_q <= iss_isel_d;
      last_q     <= last_d;
      if (arb_go_s) begin
        iss_i_q <= iss_i_d;
        iss_m_q <= iss_m_d;
        iss_l_q <= iss_l_d;
      end else begin
        iss_i_q <= iss_i_q;
        iss_m_q <= iss_m_q;
        iss_l_q <= iss_l_q;
      end
    end
  end

  // I/M/L register files: modulo writeback and host writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
      end
    end else begin
      if (wb_en_s) begin
        i_q[iss_isel_q] <= mod_newi;
      end
      if (host_hit(wr_en, wr_kind, wr_sel, KIND_I, wr_sel)) begin
        i_q[wr_sel] <= wr_data;
      end
      if (host_hit(wr_en, wr_kind, wr_sel, KIND_M, wr_sel)) begin
        m_q[wr_sel] <= wr_data;
      end
      if (host_hit(wr_en, wr_kind, wr_sel, KIND_L, wr_sel)) begin
        l_q[wr_sel] <= wr_data;
      end
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign addr_vld = iss_vld_q;
  assign addr_src = iss_src_q;
  assign addr     = iss_i_q;
  assign mod_i    = iss_i_q;
  assign mod_m    = iss_m_q;
  assign mod_l    = iss_l_q;
  // The modulo unit answers in the ISSUE cycle, so its flag is only qualified.
  assign wrap_o   = iss_vld_q && mod_wrap;

endmodule

// File: tb/tb_dag_addr_sched.sv
// -----------------------------------------------------------------------------
// tb_dag_addr_sched
//   Directed bench for dag_addr_sched. Provides a behavioural modulo unit:
//   L = 0 is linear (wraps at 2^14, flag low); otherwise the circular buffer of
//   length L starts at I rounded down to the next power of two >= L, and the
//   flag marks an update that left the buffer and was folded back.
// -----------------------------------------------------------------------------
module tb_dag_addr_sched;

  localparam int AW = 14;
  localparam int SW = 2;

  logic          clk;
  logic          rst_n;
  logic          a_req, b_req;
  logic [SW-1:0] a_isel, a_msel, b_isel, b_msel;
  logic          a_gnt, b_gnt;
  logic [AW-1:0] addr;
  logic          addr_vld, addr_src, wrap_o;
  logic [AW-1:0] mod_i, mod_m, mod_l;
  logic [AW-1:0] mod_newi;
  logic          mod_wrap;
  logic          wr_en;
  logic [1:0]    wr_kind;
  logic [SW-1:0] wr_sel;
  logic [AW-1:0] wr_data;

  int total = 0;
  int bad   = 0;

  dag_addr_sched #(.AW(AW), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_isel(a_isel), .a_msel(a_msel), .a_gnt(a_gnt),
    .b_req(b_req), .b_isel(b_isel), .b_msel(b_msel), .b_gnt(b_gnt),
    .addr(addr), .addr_vld(addr_vld), .addr_src(addr_src), .wrap_o(wrap_o),
    .mod_i(mod_i), .mod_m(mod_m), .mod_l(mod_l),
    .mod_newi(mod_newi), .mod_wrap(mod_wrap),
    .wr_en(wr_en), .wr_kind(wr_kind), .wr_sel(wr_sel), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural modulo unit
  int mu_i, mu_m, mu_l, mu_p, mu_base, mu_sum, mu_res;
  logic mu_wrap;
  always_comb begin
    mu_i = int'(mod_i);
    mu_l = int'(mod_l);
    mu_m = int'(mod_m);
    if (mod_m[AW-1]) mu_m = mu_m - 16384;
    mu_sum  = mu_i + mu_m;
    mu_res  = mu_sum;
    mu_wrap = 1'b0;
    mu_p    = 1;
    mu_base = 0;
    if (mu_l != 0) begin
      for (int k = 0; k < 15; k++) begin
        if (mu_p < mu_l) mu_p = mu_p * 2;
      end
      mu_base = mu_i - (mu_i % mu_p);
      if (mu_sum >= mu_base + mu_l) begin
        mu_res  = mu_sum - mu_l;
        mu_wrap = 1'b1;
      end else if (mu_sum < mu_base) begin
        mu_res  = mu_sum + mu_l;
        mu_wrap = 1'b1;
      end
    end
    mod_newi = AW'(mu_res & 32'h3FFF);
    mod_wrap = mu_wrap;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then settle just after the edge before looking at outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] kind, input logic [SW-1:0] sel,
                         input logic [AW-1:0] data);
    wr_en = 1'b1; wr_kind = kind; wr_sel = sel; wr_data = data;
    step();
    wr_en = 1'b0; wr_kind = 2'd3;
  endtask

  task automatic chk_issue(input string tag, input logic src,
                           input logic [AW-1:0] exp_addr, input logic exp_wrap);
    chk({tag, ".a_gnt"},    32'(a_gnt),    32'(!src));
    chk({tag, ".b_gnt"},    32'(b_gnt),    32'(src));
    chk({tag, ".addr_vld"}, 32'(addr_vld), 32'd1);
    chk({tag, ".addr_src"}, 32'(addr_src), 32'(src));
    chk({tag, ".addr"},     32'(addr),     32'(exp_addr));
    chk({tag, ".wrap"},     32'(wrap_o),   32'(exp_wrap));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".a_gnt"},    32'(a_gnt),    32'd0);
    chk({tag, ".b_gnt"},    32'(b_gnt),    32'd0);
    chk({tag, ".addr_vld"}, 32'(addr_vld), 32'd0);
    chk({tag, ".wrap"},     32'(wrap_o),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    a_isel = '0; a_msel = '0; b_isel = '0; b_msel = '0;
    wr_en = 1'b0; wr_kind = 2'd3; wr_sel = '0; wr_data = '0;
    #2;

    // Reset state
    chk_idle("rst");
    chk("rst.addr",     32'(addr),     32'd0);
    chk("rst.addr_src", 32'(addr_src), 32'd0);
    chk("rst.mod_i",    32'(mod_i),    32'd0);
    chk("rst.mod_m",    32'(mod_m),    32'd0);
    chk("rst.mod_l",    32'(mod_l),    32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk_idle("post_rst");

    // 1: circular stream on I0, buffer 0x10..0x13
    host_wr(2'd0, 2'd0, 14'h0010);
    host_wr(2'd1, 2'd0, 14'h0001);
    host_wr(2'd2, 2'd0, 14'h0004);
    a_isel = 2'd0; a_msel = 2'd0; a_req = 1'b1;
    step(); chk_issue("t1.0", 1'b0, 14'h0010, 1'b0);
    chk("t1.mod_m", 32'(mod_m), 32'h1);
    chk("t1.mod_l", 32'(mod_l), 32'h4);
    step(); chk_issue("t1.1", 1'b0, 14'h0011, 1'b0);
    step(); chk_issue("t1.2", 1'b0, 14'h0012, 1'b0);
    step(); chk_issue("t1.3", 1'b0, 14'h0013, 1'b1);
    step(); chk_issue("t1.4", 1'b0, 14'h0010, 1'b0);
    step(); chk_issue("t1.5", 1'b0, 14'h0011, 1'b0);
    a_req = 1'b0;
    step(); chk_idle("t1.end");

    // 2: simultaneous requests alternate starting with A
    host_wr(2'd0, 2'd1, 14'h0100);
    host_wr(2'd1, 2'd1, 14'h0001);
    host_wr(2'd0, 2'd2, 14'h0200);
    host_wr(2'd1, 2'd2, 14'h0002);
    a_isel = 2'd1; a_msel = 2'd1; b_isel = 2'd2; b_msel = 2'd2;
    a_req = 1'b1; b_req = 1'b1;
    step(); chk_issue("t2.0", 1'b0, 14'h0100, 1'b0);
    step(); chk_issue("t2.1", 1'b1, 14'h0200, 1'b0);
    step(); chk_issue("t2.2", 1'b0, 14'h0101, 1'b0);
    step(); chk_issue("t2.3", 1'b1, 14'h0202, 1'b0);
    a_req = 1'b0; b_req = 1'b0;
    step(); chk_idle("t2.end");

    // 3: linear back-to-back on I0 through the top of the address space
    host_wr(2'd0, 2'd0, 14'h3FFE);
    host_wr(2'd1, 2'd0, 14'h0002);
    host_wr(2'd2, 2'd0, 14'h0000);
    a_isel = 2'd0; a_msel = 2'd0; a_req = 1'b1;
    step(); chk_issue("t3.0", 1'b0, 14'h3FFE, 1'b0);
    step(); chk_issue("t3.1", 1'b0, 14'h0000, 1'b0);
    step(); chk_issue("t3.2", 1'b0, 14'h0002, 1'b0);

    // 4: host write to I0 in the ISSUE cycle of I0; writeback (0x0006) lost
    step(); chk_issue("t4.iss", 1'b0, 14'h0004, 1'b0);
    wr_en = 1'b1; wr_kind = 2'd0; wr_sel = 2'd0; wr_data = 14'h0100;
    step(); chk_idle("t4.stall");
    wr_en = 1'b0; wr_kind = 2'd3;
    step(); chk_issue("t4.new", 1'b0, 14'h0100, 1'b0);
    a_req = 1'b0;
    step(); chk_idle("t4.end");

    // 5: negative modifier, L=3, buffer 0x20..0x22
    host_wr(2'd1, 2'd0, 14'h3FFF);
    host_wr(2'd2, 2'd0, 14'h0003);
    host_wr(2'd0, 2'd0, 14'h0020);
    a_req = 1'b1;
    step(); chk_issue("t5.0", 1'b0, 14'h0020, 1'b1);
    step(); chk_issue("t5.1", 1'b0, 14'h0022, 1'b0);
    step(); chk_issue("t5.2", 1'b0, 14'h0021, 1'b0);
    step(); chk_issue("t5.3", 1'b0, 14'h0020, 1'b1);
    step(); chk_issue("t5.4", 1'b0, 14'h0022, 1'b0);

    // 6: reset in the middle of an ISSUE
    rst_n = 1'b0;
    #1;
    chk_idle("t6.rst");
    chk("t6.rst.addr", 32'(addr), 32'd0);
    a_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); chk_idle("t6.rel");
    // Tie after reset goes to A; I0/M0/L0 are back to zero
    a_isel = 2'd0; a_msel = 2'd0; b_isel = 2'd0; b_msel = 2'd0;
    a_req = 1'b1; b_req = 1'b1;
    step(); chk_issue("t6.a", 1'b0, 14'h0000, 1'b0);
    a_req = 1'b0;
    step(); chk_issue("t6.b", 1'b1, 14'h0000, 1'b0);
    b_req = 1'b0;
    step(); chk_idle("t6.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
